ipu_frame_ctrl: RTL
===================

IPU_FRAME_CTRL -- requirements
Module: ipu_frame_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning result FIFO entries (power of two, 2..16).
REQ-002 SHALL have port iCLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port iRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iEnable  input  1  host run request.
REQ-005 SHALL have port iDVAL  input  1  camera pixel valid.
REQ-006 SHALL have ports iX_Cont, iY_Cont  input  11 each  camera pixel position.
REQ-007 SHALL have ports iCoord_X, iCoord_Y  input  11 each, and iCoord_VALID  input  1, carrying the IPU detection result.
REQ-008 SHALL have port oIPU_DVAL  output  1  gated pixel valid driving the IPU.
REQ-009 SHALL have ports oX, oY  output  11 each, and oMISS  output  1, carrying the FIFO head entry.
REQ-010 SHALL have ports oVALID  output  1 and iREADY  input  1, forming the host read handshake.
REQ-011 SHALL have port oFrame_cnt  output  16  count of frames processed.
REQ-012 SHALL have port oDrop_cnt  output  8  count of results lost to FIFO full.
REQ-013 SHALL have port oBusy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL detect start-of-frame as SOF = iDVAL & iX_Cont==0 & iY_Cont==0.
REQ-015 SHALL implement states IDLE, WAIT_SOF, ACTIVE, DONE.
REQ-016 Transitions SHALL be:
- IDLE -> WAIT_SOF when iEnable=1.
- WAIT_SOF -> IDLE when iEnable=0.
- WAIT_SOF -> ACTIVE on SOF.
- ACTIVE -> DONE on iCoord_VALID without SOF.
- DONE -> ACTIVE on SOF if iEnable=1.
- DONE -> IDLE on SOF if iEnable=0.
REQ-017 In ACTIVE, SOF without iCoord_VALID SHALL push a miss entry {oMISS=1, X=0, Y=0}; the state SHALL then stay ACTIVE if iEnable=1, else go to IDLE.
REQ-018 In ACTIVE, SOF and iCoord_VALID in the same cycle SHALL push the coordinate entry (oMISS=0), not a miss, and then follow REQ-017 state rules.
REQ-019 oIPU_DVAL SHALL equal iDVAL & ((state==ACTIVE) | (SOF & iEnable & state∈{WAIT_SOF,DONE})), combinationally, so the SOF pixel reaches the IPU.
REQ-020 SHALL capture only the first iCoord_VALID per frame; iCoord_VALID in IDLE, WAIT_SOF or DONE SHALL be ignored.
REQ-021 oFrame_cnt SHALL increment on every SOF that enters or re-enters ACTIVE, and SHALL wrap 0xFFFF -> 0.
REQ-022 A pushed entry SHALL be visible on oX/oY/oMISS with oVALID=1 the cycle after the push when the FIFO was empty.
REQ-023 A pop SHALL occur when oVALID & iREADY; the next entry, or oVALID=0, SHALL appear the following cycle.
REQ-024 oX/oY/oMISS SHALL hold stable while oVALID=1 and iREADY=0.
REQ-025 A push when the FIFO is full and no pop occurs in the same cycle SHALL discard the new entry and increment oDrop_cnt, saturating at 255.
REQ-026 Simultaneous push and pop when full SHALL succeed with no drop; simultaneous push and pop when empty SHALL leave oVALID=1 with the new entry.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with a count of log2(FIFO_DEPTH)+1 bits.
REQ-028 iEnable deassertion in ACTIVE SHALL NOT abort the frame; the block SHALL finish the frame and return to IDLE per REQ-016 and REQ-017.

Reset
REQ-029 iRST=0 SHALL asynchronously set: state=IDLE; FIFO empty; oVALID=0; oX=0; oY=0; oMISS=0; oFrame_cnt=0; oDrop_cnt=0; oBusy=0.
REQ-030 During reset oIPU_DVAL SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL discard any in-progress capture and all FIFO contents.
REQ-032 After reset release the block SHALL wait for a fresh SOF before gating pixels.

Verification
REQ-033 iEnable=1; SOF; iCoord_VALID with (320,240) at pixel 500 -> next cycle oVALID=1, oX=320, oY=240, oMISS=0, oFrame_cnt=1, state DONE.
REQ-034 iEnable=1; two SOFs and no coordinate -> one miss entry (oMISS=1, 0,0), oFrame_cnt=2, state ACTIVE.
REQ-035 iREADY=0, FIFO_DEPTH=4, six frames each with a coordinate -> 4 entries held, oDrop_cnt=2, head is the frame-1 coordinate.
REQ-036 FIFO full with iREADY=1 in the same cycle as a new coordinate push -> oDrop_cnt unchanged, occupancy stays 4.
REQ-037 SOF and iCoord_VALID (10,20) in the same cycle during ACTIVE -> entry (10,20, oMISS=0), no miss entry, oFrame_cnt increments, oIPU_DVAL=1 that cycle.
REQ-038 iRST=0 mid-ACTIVE with 2 entries queued -> oVALID=0, counters 0, oIPU_DVAL=0; after release with iEnable=1, state WAIT_SOF until the next SOF.

Source files
------------

// File: rtl/ipu_frame_ctrl.sv
// Frame sequencer gating camera pixels into the IPU and queueing one result (or miss) per frame.
// Results appear one cycle after capture; host backpressure via oVALID/iREADY, overflow drops counted.
module ipu_frame_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEnable,
    input  logic        iDVAL,
    input  logic [10:0] iX_Cont,
    input  logic [10:0] iY_Cont,
    input  logic [10:0] iCoord_X,
    input  logic [10:0] iCoord_Y,
    input  logic        iCoord_VALID,
    output logic        oIPU_DVAL,
    output logic [10:0] oX,
    output logic [10:0] oY,
    output logic        oMISS,
    output logic        oVALID,
    input  logic        iREADY,
    output logic [15:0] oFrame_cnt,
    output logic [7:0]  oDrop_cnt,
    output logic        oBusy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

    typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DONE} state_t;

    typedef struct packed {
        logic        miss;
        logic [10:0] x;
        logic [10:0] y;
    } entry_t;

    state_t state, nextState;

    logic   sof;
    logic   pushReq;
    entry_t pushEntry;
    logic   frameInc;

    entry_t        mem [FIFO_DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [PW:0]   count;
    logic          pop, full, pushOk, drop;
    logic [15:0]   frameCnt;
    logic [7:0]    dropCnt;

    assign sof = iDVAL & (iX_Cont == 11'd0) & (iY_Cont == 11'd0);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        pushReq   = 1'b0;
        pushEntry = '0;
        frameInc  = 1'b0;
        case (state)
            IDLE: begin
                if (iEnable) nextState = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (!iEnable) begin
                    nextState = IDLE;
                end else if (sof) begin
                    nextState = ACTIVE;
                    frameInc  = 1'b1;
                end
            end
            ACTIVE: begin
                if (sof) begin
                    // Frame ended: report the coordinate if it lands on the SOF cycle, else a miss.
                    pushReq   = 1'b1;
                    pushEntry = iCoord_VALID ? '{1'b0, iCoord_X, iCoord_Y} : '{1'b1, 11'd0, 11'd0};
                    nextState = iEnable ? ACTIVE : IDLE;
                    frameInc  = iEnable;
                end else if (iCoord_VALID) begin
                    pushReq   = 1'b1;
                    pushEntry = '{1'b0, iCoord_X, iCoord_Y};
                    nextState = DONE;
                end
            end
            DONE: begin
                // A late disable still waits for the frame boundary.
                if (sof) begin
                    nextState = iEnable ? ACTIVE : IDLE;
                    frameInc  = iEnable;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign oIPU_DVAL = iRST & iDVAL &
                       ((state == ACTIVE) |
                        (sof & iEnable & ((state == WAIT_SOF) | (state == DONE))));
    assign oBusy     = (state != IDLE);

    assign oVALID = (count != '0);
    assign full   = (count == DEPTH_C);
    assign pop    = oVALID & iREADY;
    assign pushOk = pushReq & (~full | pop);
    assign drop   = pushReq & full & ~pop;

    always_ff @(posedge iCLK) begin
        if (pushOk) mem[wrPtr] <= pushEntry;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 1'b1;
            if (pop)    rdPtr <= rdPtr + 1'b1;
            case ({pushOk, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            frameCnt <= '0;
            dropCnt  <= '0;
        end else begin
            if (frameInc)                  frameCnt <= frameCnt + 16'd1;
            if (drop && dropCnt != 8'hFF)  dropCnt  <= dropCnt + 8'd1;
        end
    end

    // Head entry is masked while empty so stale memory never shows.
    always_comb begin
        oX    = '0;
        oY    = '0;
        oMISS = 1'b0;
        if (oVALID) begin
            oX    = mem[rdPtr].x;
            oY    = mem[rdPtr].y;
            oMISS = mem[rdPtr].miss;
        end
    end

    assign oFrame_cnt = frameCnt;
    assign oDrop_cnt  = dropCnt;

endmodule
